// File: rtl/kb_keymap_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : kb_pkg
// Brief   : PS/2 prefix and controller-byte constants and the decode state type.
// Revision: 1.0 - initial release
// ============================================================================
package kb_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  localparam logic [7:0] PS2_CTRL_ERR0   = 8'h00;
  localparam logic [7:0] PS2_CTRL_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_CTRL_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_CTRL_ACK    = 8'hFA;
  localparam logic [7:0] PS2_CTRL_RESEND = 8'hFE;
  localparam logic [7:0] PS2_CTRL_ERR1   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXT    = 2'd1,
    BRK    = 2'd2,
    EXTBRK = 2'd3
  } kb_state_t;

  // Bytes the keyboard controller emits that never carry key information.
  function automatic logic is_ctrl_byte(input logic [7:0] code);
    return (code == PS2_CTRL_ERR0)   || (code == PS2_CTRL_BAT_OK) ||
           (code == PS2_CTRL_ECHO)   || (code == PS2_CTRL_ACK)    ||
           (code == PS2_CTRL_RESEND) || (code == PS2_CTRL_ERR1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/kb_keymap_decoder_if.sv
`default_nettype none
// ============================================================================
// Module  : kb_keymap_decoder_if
// Brief   : Scan-byte handshake between the PS/2 receiver and the key decoder.
// Revision: 1.0 - initial release
// ============================================================================
interface kb_keymap_decoder_if;

  logic       scan_ready;
  logic [7:0] scan_code;
  logic       read;

  modport master (output scan_ready, output scan_code, input read);
  modport slave  (input scan_ready, input scan_code, output read);

endinterface
`default_nettype wire

// File: rtl/kb_keymap_decoder_repeat_timer.sv
`default_nettype none
// ============================================================================
// Module  : kb_repeat_timer
// Brief   : Typematic down-counter for the most recently pressed key.
// Revision: 1.0 - initial release
// ============================================================================
module kb_repeat_timer
  import kb_pkg::*;
#(
  parameter int NUM_KEYS     = 3,
  parameter int IDX_W        = 2,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                i_start,
  input  wire logic [IDX_W-1:0]    i_start_idx,
  input  wire logic                i_stop,
  output logic      [IDX_W-1:0]    o_target,
  output logic      [NUM_KEYS-1:0] o_repeat
);

  localparam int c_MAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_CNT_W = $clog2(c_MAX + 1);
  // Loading N-1 and firing at zero gives exactly N cycles between pulses.
  localparam logic [c_CNT_W-1:0]  c_DELAY_LD = c_CNT_W'(REPEAT_DELAY - 1);
  localparam logic [c_CNT_W-1:0]  c_RATE_LD  = c_CNT_W'(REPEAT_RATE - 1);
  localparam logic [NUM_KEYS-1:0] c_ONE      = NUM_KEYS'(1);

  logic [c_CNT_W-1:0]  r_count;
  logic                r_active;
  logic [IDX_W-1:0]    r_target;
  logic [NUM_KEYS-1:0] r_repeat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_active <= 1'b0;
      r_target <= '0;
      r_repeat <= '0;
    end else begin
      r_repeat <= '0;
      // A decode event in the expiry cycle pre-empts the repeat pulse.
      if (i_start) begin
        r_target <= i_start_idx;
        r_count  <= c_DELAY_LD;
        r_active <= 1'b1;
      end else if (i_stop) begin
        r_count  <= '0;
        r_active <= 1'b0;
      end else if (r_active) begin
        if (r_count == '0) begin
          r_repeat <= c_ONE << r_target;
          r_count  <= c_RATE_LD;
        end else begin
          r_count <= r_count - 1'b1;
        end
      end
    end
  end

  assign o_target = r_target;
  assign o_repeat = r_repeat;

endmodule
`default_nettype wire

// File: rtl/kb_keymap_decoder.sv
`default_nettype none
// ============================================================================
// Module  : kb_keymap_decoder
// Brief   : PS/2 scan-code decoder producing held/press/release/repeat per key.
// Revision: 1.0 - initial release
// ============================================================================
module kb_keymap_decoder
  import kb_pkg::*;
#(
  parameter int                    NUM_KEYS     = 3,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES    = {8'h72, 8'h75, 8'h5A},
  parameter logic [NUM_KEYS-1:0]   KEY_EXT      = 3'b110,
  parameter int                    REPEAT_DELAY = 25_000_000,
  parameter int                    REPEAT_RATE  = 5_000_000
) (
  input  wire logic                clk,
  input  wire logic                reset,
  kb_keymap_decoder_if.slave       rx,
  output logic      [NUM_KEYS-1:0] key_held,
  output logic      [NUM_KEYS-1:0] key_press,
  output logic      [NUM_KEYS-1:0] key_release,
  output logic      [NUM_KEYS-1:0] key_repeat,
  output logic      [7:0]          last_code,
  output logic                     last_ext
);

  localparam int         c_IDX_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam logic [1:0] c_ST_IDLE   = IDLE;
  localparam logic [1:0] c_ST_EXT    = EXT;
  localparam logic [1:0] c_ST_BRK    = BRK;
  localparam logic [1:0] c_ST_EXTBRK = EXTBRK;

  logic                r_scan_ready_q;
  logic                r_read;
  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [NUM_KEYS-1:0] r_held;
  logic [NUM_KEYS-1:0] r_press;
  logic [NUM_KEYS-1:0] r_release;
  logic [7:0]          r_last_code;
  logic                r_last_ext;

  logic                w_accept;
  logic                w_ext;
  logic                w_brk_mode;
  logic                w_data;
  logic [NUM_KEYS-1:0] w_match;
  logic [NUM_KEYS-1:0] w_make_new;
  logic [NUM_KEYS-1:0] w_brk_held;
  logic                w_start;
  logic                w_stop;
  logic [c_IDX_W-1:0]  w_start_idx;
  logic [c_IDX_W-1:0]  w_target;

  assign w_accept   = rx.scan_ready & ~r_scan_ready_q;
  assign w_ext      = (r_state == c_ST_EXT) || (r_state == c_ST_EXTBRK);
  assign w_brk_mode = (r_state == c_ST_BRK) || (r_state == c_ST_EXTBRK);
  assign w_data     = w_accept && !is_ctrl_byte(rx.scan_code) &&
                      (rx.scan_code != PS2_PFX_EXT) && (rx.scan_code != PS2_PFX_BRK);

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_match
    assign w_match[gi] = (rx.scan_code == KEY_CODES[8*gi +: 8]) && (w_ext == KEY_EXT[gi]);
  end

  // Only transitions of the held state produce pulses; keyboard typematic is absorbed.
  assign w_make_new = (w_data && !w_brk_mode) ? (w_match & ~r_held) : '0;
  assign w_brk_held = (w_data &&  w_brk_mode) ? (w_match &  r_held) : '0;
  assign w_start    = |w_make_new;
  assign w_stop     = w_data && w_brk_mode && w_match[w_target];

  always_comb begin
    w_start_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (w_make_new[i]) w_start_idx = c_IDX_W'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      if (is_ctrl_byte(rx.scan_code)) begin
        w_state_nxt = c_ST_IDLE;
      end else if (rx.scan_code == PS2_PFX_EXT) begin
        w_state_nxt = w_brk_mode ? c_ST_EXTBRK : c_ST_EXT;
      end else if (rx.scan_code == PS2_PFX_BRK) begin
        w_state_nxt = w_ext ? c_ST_EXTBRK : c_ST_BRK;
      end else begin
        w_state_nxt = c_ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_ready_q <= 1'b0;
      r_read         <= 1'b0;
      r_state        <= c_ST_IDLE;
      r_held         <= '0;
      r_press        <= '0;
      r_release      <= '0;
      r_last_code    <= '0;
      r_last_ext     <= 1'b0;
    end else begin
      r_scan_ready_q <= rx.scan_ready;
      r_read         <= w_accept;
      r_state        <= w_state_nxt;
      r_held         <= (r_held | w_make_new) & ~w_brk_held;
      r_press        <= w_make_new;
      r_release      <= w_brk_held;
      if (w_data) begin
        r_last_code <= rx.scan_code;
        r_last_ext  <= w_ext;
      end
    end
  end

  kb_repeat_timer #(
    .NUM_KEYS     (NUM_KEYS),
    .IDX_W        (c_IDX_W),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_repeat_timer (
    .clk         (clk),
    .rst         (reset),
    .i_start     (w_start),
    .i_start_idx (w_start_idx),
    .i_stop      (w_stop),
    .o_target    (w_target),
    .o_repeat    (key_repeat)
  );

  assign rx.read     = r_read;
  assign key_held    = r_held;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign last_code   = r_last_code;
  assign last_ext    = r_last_ext;

endmodule
`default_nettype wire

// File: tb/tb_kb_keymap_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_kb_keymap_decoder
// Brief   : Scoreboard bench for kb_keymap_decoder with short repeat timing.
// Revision: 1.0 - initial release
// ============================================================================
module tb_kb_keymap_decoder;

  typedef struct {
    logic [2:0] press;
    logic [2:0] release_;
    logic [2:0] held;
    logic [7:0] code;
    logic       ext;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] key_held, key_press, key_release, key_repeat;
  logic [7:0] last_code;
  logic       last_ext;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: states 0=IDLE 1=EXT 2=BRK 3=EXTBRK
  int         m_state = 0;
  logic [2:0] m_held = '0;
  logic [7:0] m_code = '0;
  logic       m_ext = 1'b0;
  logic [7:0] m_keys [3] = '{8'h5A, 8'h75, 8'h72};
  logic [2:0] m_kext = 3'b110;

  kb_keymap_decoder_if bus();

  kb_keymap_decoder #(
    .NUM_KEYS     (3),
    .KEY_CODES    ({8'h72, 8'h75, 8'h5A}),
    .KEY_EXT      (3'b110),
    .REPEAT_DELAY (20),
    .REPEAT_RATE  (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (bus),
    .key_held    (key_held),
    .key_press   (key_press),
    .key_release (key_release),
    .key_repeat  (key_repeat),
    .last_code   (last_code),
    .last_ext    (last_ext)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.read) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL read_unexpected got read=1 exp no pending byte");
      end else begin
        mon_e = exp_q.pop_front();
        if (key_press !== mon_e.press || key_release !== mon_e.release_ ||
            key_held !== mon_e.held || last_code !== mon_e.code || last_ext !== mon_e.ext) begin
          n_errors++;
          $display("FAIL decode got p=%b r=%b h=%b code=%h ext=%b exp p=%b r=%b h=%b code=%h ext=%b",
                   key_press, key_release, key_held, last_code, last_ext,
                   mon_e.press, mon_e.release_, mon_e.held, mon_e.code, mon_e.ext);
        end
      end
    end else if (!reset) begin
      n_checks++;
      if (key_press !== 3'b000 || key_release !== 3'b000) begin
        n_errors++;
        $display("FAIL idle_pulse got p=%b r=%b exp 000 000", key_press, key_release);
      end
    end
  end

  task automatic start_byte(input logic [7:0] b);
    exp_t e;
    logic ext, brk;
    e.press = '0;
    e.release_ = '0;
    if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
      m_state = 0;
    end else if (b == 8'hE0) begin
      m_state = (m_state >= 2) ? 3 : 1;
    end else if (b == 8'hF0) begin
      m_state = (m_state == 1 || m_state == 3) ? 3 : 2;
    end else begin
      ext = (m_state == 1 || m_state == 3);
      brk = (m_state >= 2);
      for (int i = 0; i < 3; i++) begin
        if (b == m_keys[i] && ext == m_kext[i]) begin
          if (!brk && !m_held[i]) begin
            e.press[i] = 1'b1;
            m_held[i] = 1'b1;
          end else if (brk && m_held[i]) begin
            e.release_[i] = 1'b1;
            m_held[i] = 1'b0;
          end
        end
      end
      m_code = b;
      m_ext = ext;
      m_state = 0;
    end
    e.held = m_held;
    e.code = m_code;
    e.ext = m_ext;
    exp_q.push_back(e);
    bus.scan_code = b;
    bus.scan_ready = 1'b1;
  endtask

  task automatic finish_byte();
    bus.scan_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    start_byte(b);
    @(posedge clk); #1;
    finish_byte();
  endtask

  task automatic wait_repeat(output int at);
    int k = 0;
    while (key_repeat === 3'b000 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    at = cyc;
    n_checks++;
    if (key_repeat === 3'b000) begin
      n_errors++;
      $display("FAIL repeat_timeout got no key_repeat in 60 cycles exp a pulse");
    end
  endtask

  task automatic check_quiet(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (key_repeat !== 3'b000) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++;
      $display("FAIL %s got %0d repeat pulses exp 0", name, seen);
    end
  endtask

  task automatic test_reset();
    bus.scan_ready = 1'b0;
    bus.scan_code = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({key_held, key_press, key_release, key_repeat, last_code, last_ext, bus.read} !== 22'd0) begin
      n_errors++;
      $display("FAIL reset_outputs got h=%b p=%b r=%b rp=%b code=%h ext=%b read=%b exp all 0",
               key_held, key_press, key_release, key_repeat, last_code, last_ext, bus.read);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_make_break();
    send_byte(8'h5A);
    n_checks++;
    if (key_held !== 3'b001) begin
      n_errors++;
      $display("FAIL t1_held got %b exp 001", key_held);
    end
    send_byte(8'hF0);
    send_byte(8'h5A);
    n_checks++;
    if (key_held !== 3'b000) begin
      n_errors++;
      $display("FAIL t1_released got %b exp 000", key_held);
    end
  endtask

  task automatic test_extended();
    send_byte(8'hE0);
    send_byte(8'h75);
    n_checks++;
    if (key_held !== 3'b010 || last_ext !== 1'b1) begin
      n_errors++;
      $display("FAIL t2_ext_press got h=%b ext=%b exp 010 1", key_held, last_ext);
    end
    send_byte(8'h75);
    n_checks++;
    if (last_code !== 8'h75 || last_ext !== 1'b0 || key_held !== 3'b010) begin
      n_errors++;
      $display("FAIL t2_plain got code=%h ext=%b h=%b exp 75 0 010", last_code, last_ext, key_held);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    n_checks++;
    if (key_held !== 3'b000) begin
      n_errors++;
      $display("FAIL t2_e0f0_break got %b exp 000", key_held);
    end
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'hF0);
    send_byte(8'hE0);
    send_byte(8'h75);
    n_checks++;
    if (key_held !== 3'b000) begin
      n_errors++;
      $display("FAIL t2_f0e0_break got %b exp 000", key_held);
    end
  endtask

  task automatic test_repeat();
    int t_press, t1, t2, t3;
    send_byte(8'hE0);
    send_byte(8'h72);
    t_press = cyc - 1;
    send_byte(8'hE0);
    send_byte(8'h72);
    wait_repeat(t1);
    n_checks++;
    if (key_repeat !== 3'b100 || (t1 - t_press) != 20) begin
      n_errors++;
      $display("FAIL t3_first_repeat got rp=%b after %0d exp 100 after 20", key_repeat, t1 - t_press);
    end
    @(posedge clk); #1;
    wait_repeat(t2);
    n_checks++;
    if (key_repeat !== 3'b100 || (t2 - t1) != 5) begin
      n_errors++;
      $display("FAIL t3_rate1 got rp=%b after %0d exp 100 after 5", key_repeat, t2 - t1);
    end
    @(posedge clk); #1;
    wait_repeat(t3);
    n_checks++;
    if (key_repeat !== 3'b100 || (t3 - t2) != 5) begin
      n_errors++;
      $display("FAIL t3_rate2 got rp=%b after %0d exp 100 after 5", key_repeat, t3 - t2);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h72);
    check_quiet("t3_stop", 30);
  endtask

  task automatic test_hold_and_ctrl();
    int reads = 0;
    start_byte(8'h5A);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.read === 1'b1) reads++;
    end
    finish_byte();
    n_checks++;
    if (reads != 1) begin
      n_errors++;
      $display("FAIL t4_single_read got %0d reads exp 1", reads);
    end
    send_byte(8'hF0);
    send_byte(8'h5A);
    send_byte(8'hE0);
    send_byte(8'hAA);
    send_byte(8'h75);
    n_checks++;
    if (key_held !== 3'b000 || last_code !== 8'h75 || last_ext !== 1'b0) begin
      n_errors++;
      $display("FAIL t4_ctrl_reset_state got h=%b code=%h ext=%b exp 000 75 0", key_held, last_code, last_ext);
    end
  endtask

  task automatic test_retarget();
    int t_up, r;
    send_byte(8'h5A);
    send_byte(8'hE0);
    send_byte(8'h75);
    t_up = cyc - 1;
    n_checks++;
    if (key_held !== 3'b011) begin
      n_errors++;
      $display("FAIL t5_both_held got %b exp 011", key_held);
    end
    wait_repeat(r);
    n_checks++;
    if (key_repeat !== 3'b010 || (r - t_up) != 20) begin
      n_errors++;
      $display("FAIL t5_retarget got rp=%b after %0d exp 010 after 20", key_repeat, r - t_up);
    end
    // Break byte lands on the edge where the next repeat would fire.
    send_byte(8'hE0);
    send_byte(8'hF0);
    start_byte(8'h75);
    @(posedge clk); #1;
    n_checks++;
    if (key_repeat !== 3'b000 || key_release !== 3'b010) begin
      n_errors++;
      $display("FAIL t5_expiry_collision got rp=%b rel=%b exp 000 010", key_repeat, key_release);
    end
    finish_byte();
    check_quiet("t5_idle_after_break", 30);
    send_byte(8'hF0);
    send_byte(8'h5A);
  endtask

  task automatic test_reset_mid();
    send_byte(8'h5A);
    send_byte(8'hE0);
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({key_held, key_press, key_release, key_repeat, last_code, last_ext, bus.read} !== 22'd0) begin
      n_errors++;
      $display("FAIL t6_reset_outputs got h=%b p=%b r=%b rp=%b code=%h ext=%b read=%b exp all 0",
               key_held, key_press, key_release, key_repeat, last_code, last_ext, bus.read);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    m_state = 0;
    m_held = '0;
    m_code = '0;
    m_ext = 1'b0;
    @(posedge clk); #1;
    send_byte(8'h75);
    n_checks++;
    if (key_held !== 3'b000 || last_ext !== 1'b0) begin
      n_errors++;
      $display("FAIL t6_prefix_dropped got h=%b ext=%b exp 000 0", key_held, last_ext);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_repeat();
    test_hold_and_ctrl();
    test_retarget();
    test_reset_mid();
    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
